rx_frame_assembler: RTL

Parametrised frame back-end for the receive chain. It sits after `bits_detector` and takes over the job `crc16` does today. It gathers the serial decoded bits between `sof` and `eof` into `WORD_WIDTH` words and buffers them in an output FIFO with valid/ready and last-word tagging. It also runs a configurable bit-serial CRC with residue check and reports bit count and overflow, so `ctrl_fsm` or a host interface can consume whole frames instead of single bits.

---
 rtl/rx_frame_assembler.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/rx_frame_assembler.sv
// rx_frame_assembler
// ------------------
// Receive-chain frame back-end. It collects the decoded serial bits between
// sof and eof into WORD_WIDTH-bit words (first bit in the MSB). The last
// completed word is held in a one-entry staging register so that it can be
// tagged as the frame's final word if nothing follows it. Words go into a
// first-word-fall-through output FIFO with valid/ready. A bit-serial CRC
// runs over every accepted bit and is checked against a fixed residue when
// the frame ends.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   sof, eof          frame start / end pulses
//   in_dat, in_vld    decoded bit and its qualifier
//   out_dat/out_last  FIFO head word and its end-of-frame tag
//   out_vld/out_rdy   FIFO head handshake
//   frame_done        one-cycle pulse when a frame is fully committed
//   crc_ok            residue matched for the last finished frame
//   bit_count         bits accepted in the current or last frame
//   overflow          sticky: frame aborted on FIFO full or MAX_BITS
module rx_frame_assembler #(
    parameter int                   WORD_WIDTH  = 8,
    parameter int                   FIFO_DEPTH  = 4,
    parameter int                   CRC_WIDTH   = 16,
    parameter logic [CRC_WIDTH-1:0] CRC_POLY    = 16'h1021,
    parameter logic [CRC_WIDTH-1:0] CRC_INIT    = 16'hFFFF,
    parameter logic [CRC_WIDTH-1:0] CRC_RESIDUE = 16'h1D0F,
    parameter int                   MAX_BITS    = 512
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sof,
    input  logic                          eof,
    input  logic                          in_dat,
    input  logic                          in_vld,
    output logic [WORD_WIDTH-1:0]         out_dat,
    output logic                          out_last,
    output logic                          out_vld,
    input  logic                          out_rdy,
    output logic                          frame_done,
    output logic                          crc_ok,
    output logic [$clog2(MAX_BITS+1)-1:0] bit_count,
    output logic                          overflow
);

    localparam int BCW = $clog2(MAX_BITS + 1);
    localparam int PCW = $clog2(WORD_WIDTH + 1);
    localparam int AW  = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_FLUSH} state_t;

    state_t                state_q;
    logic [CRC_WIDTH-1:0]  crc_q;
    logic [BCW-1:0]        cnt_q;
    logic [WORD_WIDTH-1:0] part_q;      // partial word, right-justified
    logic [PCW-1:0]        pcnt_q;      // bits held in part_q
    logic [WORD_WIDTH-1:0] stg_q;
    logic                  stg_vld_q;
    logic                  frame_done_q;
    logic                  crc_ok_q;
    logic                  ovf_q;

    // Output FIFO: {last, word} per entry.
    logic [WORD_WIDTH:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_q, rd_q;
    logic [AW:0]           fcnt_q;

    logic                  pop, space, accept, cap_hit, ovf_event;
    logic                  push_en, push_last;
    logic [WORD_WIDTH-1:0] push_word, part_left, word_d;
    logic [CRC_WIDTH-1:0]  crc_d;
    logic [PCW-1:0]        shamt;
    logic                  fb;

    assign out_vld    = (fcnt_q != '0);
    assign out_dat    = out_vld ? mem[rd_q][WORD_WIDTH-1:0] : '0;
    assign out_last   = out_vld && mem[rd_q][WORD_WIDTH];
    assign frame_done = frame_done_q;
    assign crc_ok     = crc_ok_q;
    assign bit_count  = cnt_q;
    assign overflow   = ovf_q;

    assign pop   = out_vld && out_rdy;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign space = (fcnt_q != (AW+1)'(FIFO_DEPTH)) || pop;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        fb        = crc_q[CRC_WIDTH-1] ^ in_dat;
        crc_d     = {crc_q[CRC_WIDTH-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
        word_d    = {part_q[WORD_WIDTH-2:0], in_dat};
        shamt     = PCW'(WORD_WIDTH) - pcnt_q;
        part_left = part_q << shamt;

        accept    = (state_q == S_RECV) && in_vld && !sof;
        cap_hit   = (cnt_q == BCW'(MAX_BITS));
        ovf_event = accept && (cap_hit || (stg_vld_q && !space));

        push_en   = 1'b0;
        push_last = 1'b0;
        push_word = stg_q;
        if (state_q == S_RECV) begin
            // The staged word leaves when the next bit arrives, proving it is not last.
            push_en = accept && stg_vld_q && !ovf_event;
        end else if (state_q == S_FLUSH && !sof && (stg_vld_q || pcnt_q != '0) && space) begin
            push_en   = 1'b1;
            push_last = stg_vld_q ? (pcnt_q == '0) : 1'b1;
            push_word = stg_vld_q ? stg_q : part_left;
        end
    end

    // NOTE: the FIFO storage has no reset; only the pointers and count need one.
    always_ff @(posedge clk) begin
        if (push_en && !rst) mem[wr_q] <= {push_last, push_word};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q   <= '0;
            rd_q   <= '0;
            fcnt_q <= '0;
        end else begin
            if (push_en) wr_q <= wr_q + 1'b1;
            if (pop)     rd_q <= rd_q + 1'b1;
            fcnt_q <= fcnt_q + (AW+1)'(push_en) - (AW+1)'(pop);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            crc_q        <= '0;
            cnt_q        <= '0;
            part_q       <= '0;
            pcnt_q       <= '0;
            stg_q        <= '0;
            stg_vld_q    <= 1'b0;
            frame_done_q <= 1'b0;
            crc_ok_q     <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (sof) begin
                // Start (or restart) a frame; FIFO contents are left alone.
                state_q   <= S_RECV;
                crc_q     <= CRC_INIT;
                cnt_q     <= '0;
                part_q    <= '0;
                pcnt_q    <= '0;
                stg_vld_q <= 1'b0;
                crc_ok_q  <= 1'b0;
                ovf_q     <= 1'b0;
            end else begin
                case (state_q)
                    S_RECV: begin
                        if (ovf_event) begin
                            ovf_q     <= 1'b1;
                            stg_vld_q <= 1'b0;
                            part_q    <= '0;
                            pcnt_q    <= '0;
                            state_q   <= S_IDLE;
                        end else begin
                            if (accept) begin
                                crc_q <= crc_d;
                                cnt_q <= cnt_q + 1'b1;
                                if (stg_vld_q) stg_vld_q <= 1'b0;
                                if (pcnt_q == PCW'(WORD_WIDTH - 1)) begin
                                    stg_q     <= word_d;
                                    stg_vld_q <= 1'b1;
                                    part_q    <= '0;
                                    pcnt_q    <= '0;
                                end else begin
                                    part_q <= word_d;
                                    pcnt_q <= pcnt_q + 1'b1;
                                end
                            end
                            if (eof) begin
                                if (!accept && cnt_q == '0) begin
                                    // Empty frame: nothing to push.
                                    frame_done_q <= 1'b1;
                                    crc_ok_q     <= 1'b0;
                                    state_q      <= S_IDLE;
                                end else begin
                                    state_q <= S_FLUSH;
                                end
                            end
                        end
                    end
                    S_FLUSH: begin
                        if (push_en) begin
                            if (stg_vld_q) stg_vld_q <= 1'b0;
                            else           pcnt_q    <= '0;
                        end
                        // Finish in the cycle of the final push so frame_done follows it directly.
                        if (push_last || (!stg_vld_q && pcnt_q == '0)) begin
                            frame_done_q <= 1'b1;
                            crc_ok_q     <= (crc_q == CRC_RESIDUE) && (int'(cnt_q) >= CRC_WIDTH);
                            part_q       <= '0;
                            pcnt_q       <= '0;
                            state_q      <= S_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
